// File: rtl/wpair_pkg.sv
// Shared types and constants for the wpair pair-link transmitter.
// Optional equal-run statistics are built when WPAIR_MATCH_STAT_EN is defined.
package wpair_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic IDLE_W1 = 1'b0;
    localparam logic IDLE_W2 = 1'b1;

    localparam int GAP_W = 4;

    function automatic int cnt_w(input int pairs);
        return $clog2(pairs) + 1;
    endfunction

endpackage

// File: rtl/wpair_run_stat.sv
// Equal-run counter and longest-run tracker over the transmitted pairs.
// Publishes the frame's longest run on the cycle after its last pair.
module wpair_run_stat
    import wpair_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             clear,
    input  logic             valid,
    input  logic             w1,
    input  logic             w2,
    input  logic             last,
    output logic [CNT_W-1:0] match_max
);

    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic [CNT_W-1:0] max_q, max_d;

    always_comb begin
        run_d  = run_q;
        best_d = best_q;
        max_d  = max_q;
        if (clear) begin
            run_d  = '0;
            best_d = '0;
        end else if (valid) begin
            run_d  = (w1 == w2) ? run_q + CNT_W'(1) : '0;
            best_d = (run_d > best_q) ? run_d : best_q;
            // best_d already includes the last pair of the frame
            if (last) begin
                max_d = best_d;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            run_q  <= '0;
            best_q <= '0;
            max_q  <= '0;
        end else begin
            run_q  <= run_d;
            best_q <= best_d;
            max_q  <= max_d;
        end
    end

    assign match_max = max_q;

endmodule

// File: rtl/wpair_stream_tx.sv
// Serialises a PAIRS-wide (w1, w2) frame LSB first, idling on the unequal pair (0,1).
// Define WPAIR_MATCH_STAT_EN to build the longest equal-run statistic on match_max.
module wpair_stream_tx
    import wpair_pkg::*;
#(
    parameter  int PAIRS = 8,
    parameter  int GAP   = 2,
    localparam int CNT_W = cnt_w(PAIRS)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAIRS-1:0] load_w1,
    input  logic [PAIRS-1:0] load_w2,
    output logic             w1,
    output logic             w2,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_max
);

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(PAIRS - 1);
    localparam logic [CNT_W-1:0] IDX_PEN  = CNT_W'(PAIRS - 2);
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [PAIRS-1:0] sh1_q, sh1_d;
    logic [PAIRS-1:0] sh2_q, sh2_d;
    logic             w1_q, w1_d;
    logic             w2_q, w2_d;
    logic             w_valid_q, w_valid_d;
    logic             done_q, done_d;
    logic             accept;

    assign accept = (state_q == ST_IDLE) && load_valid;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        w_valid_d = w_valid_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SEND;
                    idx_d     = '0;
                    w1_d      = load_w1[0];
                    w2_d      = load_w2[0];
                    sh1_d     = load_w1 >> 1;
                    sh2_d     = load_w2 >> 1;
                    w_valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (idx_q == IDX_LAST) begin
                    idx_d     = '0;
                    w1_d      = IDLE_W1;
                    w2_d      = IDLE_W2;
                    w_valid_d = 1'b0;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d  = idx_q + CNT_W'(1);
                    w1_d   = sh1_q[0];
                    w2_d   = sh2_q[0];
                    sh1_d  = sh1_q >> 1;
                    sh2_d  = sh2_q >> 1;
                    // done rides with the last pair, not after it
                    done_d = (idx_q == IDX_PEN);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                w1_d      = IDLE_W1;
                w2_d      = IDLE_W2;
                w_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            sh1_q     <= '0;
            sh2_q     <= '0;
            w1_q      <= IDLE_W1;
            w2_q      <= IDLE_W2;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            w_valid_q <= w_valid_d;
            done_q    <= done_d;
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign w1         = w1_q;
    assign w2         = w2_q;
    assign w_valid    = w_valid_q;
    assign done       = done_q;

`ifdef WPAIR_MATCH_STAT_EN
    wpair_run_stat #(
        .CNT_W(CNT_W)
    ) u_stat (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .clear     (accept),
        .valid     (w_valid_q),
        .w1        (w1_q),
        .w2        (w2_q),
        .last      (done_q),
        .match_max (match_max)
    );
`else
    assign match_max = '0;
`endif

endmodule

// File: tb/tb_wpair_stream_tx.sv
// Bench for wpair_stream_tx: random frames against a frame-level reference model.
// Expected match_max follows WPAIR_MATCH_STAT_EN the same way as the design build.
module tb_wpair_stream_tx;

    localparam int P  = 8;
    localparam int G  = 2;
    localparam int CW = $clog2(P) + 1;
`ifdef WPAIR_MATCH_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [P-1:0]  load_w1 = '0;
    logic [P-1:0]  load_w2 = '0;
    logic          w1, w2, w_valid, busy, done;
    logic [CW-1:0] match_max;

    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] exp_max = '0;

    always #5 Clock = ~Clock;

    wpair_stream_tx #(
        .PAIRS(P),
        .GAP  (G)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_w1    (load_w1),
        .load_w2    (load_w2),
        .w1         (w1),
        .w2         (w2),
        .w_valid    (w_valid),
        .busy       (busy),
        .done       (done),
        .match_max  (match_max)
    );

    // Longest window of positions where both words agree, by brute force.
    function automatic logic [CW-1:0] longest(input logic [P-1:0] a,
                                              input logic [P-1:0] b);
        int best;
        bit all;
        best = 0;
        for (int s = 0; s < P; s++) begin
            for (int l = 1; l <= P - s; l++) begin
                all = 1'b1;
                for (int j = s; j < s + l; j++)
                    if (a[j] !== b[j]) all = 1'b0;
                if (all && l > best) best = l;
            end
        end
        return STAT ? CW'(best) : '0;
    endfunction

    task automatic wait_ready(input string tag, output bit ok);
        int t;
        t = 0;
        @(negedge Clock);
        while (load_ready !== 1'b1 && t < 50) begin
            @(negedge Clock);
            t++;
        end
        ok = (t < 50);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_ready_timeout: load_ready=%b expected 1", tag, load_ready);
        end
    endtask

    task automatic test_frame(input logic [P-1:0] a, input logic [P-1:0] b,
                              input bit toggle, input string tag);
        logic [CW+5:0] obs, exp;
        logic [CW-1:0] new_max;
        logic          ew1, ew2, ewv, edn, eby, elr;
        logic [CW-1:0] emm;
        bit            ok;
        new_max = longest(a, b);
        wait_ready(tag, ok);
        if (!ok) return;
        load_w1    = a;
        load_w2    = b;
        load_valid = 1'b1;
        for (int c = 0; c <= P + G; c++) begin
            @(negedge Clock);
            if (c < P) begin
                ew1 = a[c]; ew2 = b[c]; ewv = 1'b1;
                edn = (c == P - 1); eby = 1'b1; elr = 1'b0; emm = exp_max;
            end else if (c < P + G) begin
                ew1 = 1'b0; ew2 = 1'b1; ewv = 1'b0;
                edn = 1'b0; eby = 1'b1; elr = 1'b0; emm = new_max;
            end else begin
                ew1 = 1'b0; ew2 = 1'b1; ewv = 1'b0;
                edn = 1'b0; eby = 1'b0; elr = 1'b1; emm = new_max;
            end
            obs = {w1, w2, w_valid, done, busy, load_ready, match_max};
            exp = {ew1, ew2, ewv, edn, eby, elr, emm};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d {w1,w2,wv,done,busy,rdy,max}: got %b expected %b",
                         tag, c, obs, exp);
            end
            if (toggle && c < P - 1) begin
                load_valid = 1'($urandom);
                load_w1    = P'($urandom);
                load_w2    = P'($urandom);
            end else begin
                load_valid = 1'b0;
            end
        end
        exp_max = new_max;
    endtask

    task automatic test_reset();
        Resetn     = 1'b0;
        load_valid = 1'b0;
        repeat (3) @(negedge Clock);
        vectors++;
        if ({w1, w2, w_valid, done, busy, match_max} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b",
                     {w1, w2, w_valid, done, busy, match_max},
                     {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}});
        end
        Resetn = 1'b1;
        @(negedge Clock);
        vectors++;
        if (load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 1", load_ready);
        end
        exp_max = '0;
    endtask

    task automatic test_basic();
        test_frame(8'hA5, 8'h5A, 1'b0, "basic");
    endtask

    task automatic test_stats();
        test_frame(8'hFF, 8'h0F, 1'b0, "stats_4");
        test_frame(8'h00, 8'h00, 1'b0, "stats_8");
    endtask

    task automatic test_load_ignored();
        repeat (4) test_frame(P'($urandom), P'($urandom), 1'b1, "busy_ignore");
    endtask

    task automatic test_random();
        logic [P-1:0] a;
        repeat (6) begin
            a = P'($urandom);
            test_frame(a, a ^ (P'($urandom) & P'($urandom)), 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        localparam int NC = 3 * (P + G + 1) + 4;
        logic [P-1:0] fa[3], fb[3], gw1[3], gw2[3];
        logic         r_w1[$], r_w2[$], r_v[$], r_d[$];
        int           gaps[$];
        int           n_acc, nv, dn, bad_idle, bad_done, zeros;
        bit           seen, ok;
        for (int f = 0; f < 3; f++) begin
            fa[f] = P'($urandom);
            fb[f] = P'($urandom);
        end
        wait_ready("b2b", ok);
        if (!ok) return;
        load_w1    = fa[0];
        load_w2    = fb[0];
        load_valid = 1'b1;
        n_acc      = 0;
        for (int cyc = 0; cyc < NC; cyc++) begin
            r_w1.push_back(w1);
            r_w2.push_back(w2);
            r_v.push_back(w_valid);
            r_d.push_back(done);
            if (load_ready === 1'b1 && load_valid) begin
                n_acc++;
                @(posedge Clock);
                #1;
                if (n_acc < 3) begin
                    load_w1 = fa[n_acc];
                    load_w2 = fb[n_acc];
                end else begin
                    load_valid = 1'b0;
                end
            end
            @(negedge Clock);
        end
        load_valid = 1'b0;
        nv = 0; dn = 0; bad_idle = 0; bad_done = 0; zeros = 0; seen = 1'b0;
        for (int f = 0; f < 3; f++) begin
            gw1[f] = '0;
            gw2[f] = '0;
        end
        for (int i = 0; i < r_v.size(); i++) begin
            if (r_v[i] === 1'b1) begin
                if (seen && zeros > 0) gaps.push_back(zeros);
                seen  = 1'b1;
                zeros = 0;
                if (nv < 3 * P) begin
                    gw1[nv / P][nv % P] = r_w1[i];
                    gw2[nv / P][nv % P] = r_w2[i];
                end
                nv++;
                if (r_d[i] === 1'b1) begin
                    dn++;
                    if (nv % P != 0) bad_done++;
                end
            end else begin
                zeros++;
                if (r_w1[i] !== 1'b0 || r_w2[i] !== 1'b1) bad_idle++;
                if (r_d[i] !== 1'b0) begin
                    dn++;
                    bad_done++;
                end
            end
        end
        vectors++;
        if (nv != 3 * P) begin
            miscompares++;
            $display("FAIL b2b_pair_count: got %0d expected %0d", nv, 3 * P);
        end
        for (int f = 0; f < 3; f++) begin
            vectors++;
            if ({gw1[f], gw2[f]} !== {fa[f], fb[f]}) begin
                miscompares++;
                $display("FAIL b2b_frame%0d: got %h/%h expected %h/%h",
                         f, gw1[f], gw2[f], fa[f], fb[f]);
            end
        end
        vectors++;
        if (gaps.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_gap_count: got %0d expected 2", gaps.size());
        end
        foreach (gaps[g]) begin
            vectors++;
            if (gaps[g] != G + 1) begin
                miscompares++;
                $display("FAIL b2b_gap%0d: got %0d idle cycles expected %0d",
                         g, gaps[g], G + 1);
            end
        end
        vectors++;
        if (dn != 3 || bad_done != 0) begin
            miscompares++;
            $display("FAIL b2b_done: got %0d pulses (%0d misplaced) expected 3 (0)",
                     dn, bad_done);
        end
        vectors++;
        if (bad_idle != 0) begin
            miscompares++;
            $display("FAIL b2b_idle_pair: got %0d bad idle cycles expected 0", bad_idle);
        end
        exp_max = longest(fa[2], fb[2]);
        vectors++;
        if (match_max !== exp_max) begin
            miscompares++;
            $display("FAIL b2b_match_max: got %0d expected %0d", match_max, exp_max);
        end
    endtask

    task automatic test_reset_mid();
        logic [P-1:0] a, b;
        int           dn;
        bit           ok;
        a = P'($urandom);
        b = P'($urandom);
        wait_ready("reset_mid", ok);
        if (!ok) return;
        load_w1    = a;
        load_w2    = b;
        load_valid = 1'b1;
        @(negedge Clock);
        load_valid = 1'b0;
        repeat (3) @(negedge Clock);
        vectors++;
        if ({w1, w2, w_valid} !== {a[3], b[3], 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid_pair3: got %b expected %b",
                     {w1, w2, w_valid}, {a[3], b[3], 1'b1});
        end
        #2 Resetn = 1'b0;
        #1;
        vectors++;
        if ({w1, w2, w_valid, busy, done, match_max} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %b expected %b",
                     {w1, w2, w_valid, busy, done, match_max},
                     {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}});
        end
        dn = 0;
        repeat (3) begin
            @(negedge Clock);
            if (done !== 1'b0) dn++;
        end
        Resetn  = 1'b1;
        exp_max = '0;
        repeat (6) begin
            @(negedge Clock);
            if (done !== 1'b0) dn++;
        end
        vectors++;
        if (dn != 0) begin
            miscompares++;
            $display("FAIL reset_mid_done: got %0d done cycles expected 0", dn);
        end
        vectors++;
        if ({load_ready, busy, match_max} !== {1'b1, 1'b0, {CW{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_mid_release: got %b expected %b",
                     {load_ready, busy, match_max}, {1'b1, 1'b0, {CW{1'b0}}});
        end
        test_frame(P'($urandom), P'($urandom), 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stats();
        test_load_ignored();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wpair_stream_tx.md
Name: wpair_stream_tx

Overview:
- Transmit end of the two-wire (w1, w2) pair interface used by the match-run detector FSMs in this design.
- Accepts a parallel frame of PAIRS bit-pairs through a valid/ready load port and serialises it, one (w1, w2) pair per Clock, LSB first.
- Between frames it drives a guaranteed-unequal idle pair so the downstream detector cannot fire on idle.
- Serves as on-chip stimulus for the detector and as the source side of the pair link.

Parameters:
- PAIRS, 8: number of bit-pairs per frame, minimum 2.
- GAP, 2: number of idle cycles forced after each frame, 0..15.
- CNT_W (localparam), $clog2(PAIRS)+1: width of the pair index and of the statistics counters.

Ports:
- Clock, in, 1: single clock; all logic is rising-edge.
- Resetn, in, 1: asynchronous active-low reset.
- load_valid, in, 1: frame offered.
- load_ready, out, 1: block can accept a frame.
- load_w1, in, PAIRS: w1 bits of the frame; bit 0 is sent first.
- load_w2, in, PAIRS: w2 bits of the frame; bit 0 is sent first.
- w1, out, 1: serial w1 (registered).
- w2, out, 1: serial w2 (registered).
- w_valid, out, 1: high while frame pairs are driven.
- busy, out, 1: state is not IDLE.
- done, out, 1: one-cycle pulse coincident with the last pair.
- match_max, out, CNT_W: longest run of w1==w2 pairs in the last completed frame.

Behaviour:
- Clock and reset: one clock, Clock. Reset is asynchronous, active-low, on Resetn. The reset input is asynchronous; it is not synchronised inside this block.
- Reset values: state=IDLE, w1=0, w2=1 (idle pair), w_valid=0, done=0, match_max=0, shift registers and index cleared.
- load_ready: equals (state==IDLE). It is therefore 1 from the first cycle after reset release.
- States and transitions:
  - IDLE: on load_valid && load_ready at edge k, capture load_w1/load_w2, go to SEND.
  - SEND: pair i (i=0..PAIRS-1) is on w1/w2 with w_valid=1 during cycle k+1+i. done=1 during cycle k+PAIRS. After the last pair, go to GAP if GAP>0, else to IDLE.
  - GAP: drive the idle pair (0,1) with w_valid=0 for exactly GAP cycles, then go to IDLE.
- Back-to-back frames: with load_valid held high, consecutive frames are separated by exactly GAP+1 idle-pair cycles (GAP cycles plus one IDLE cycle).
- Load port: load_w1/load_w2 are sampled only on the accepting edge. Changes at any other time are ignored.
- Idle pair: (0,1) is driven in IDLE and GAP and is never equal, so any downstream equal-run count restarts.
- Reset mid-frame: the frame is aborted immediately. Outputs go to reset values, no done pulse is produced, and match_max is cleared.
- Index counter: CNT_W bits; terminates at PAIRS-1 with no wrap visible externally.

Optional Feature:
- Macro: WPAIR_MATCH_STAT_EN.
- When defined:
  - A run counter tracks consecutive w1==w2 pairs within the frame, and a max register tracks the longest run.
  - Both counters clear on frame acceptance.
  - match_max updates on the done cycle, becoming visible from cycle k+PAIRS+1, and holds until the next done or reset.
  - The maximum possible value is PAIRS.
- When undefined: match_max is tied to 0 and no counters are synthesised.

Decomposition:
- Shared package wpair_pkg:
  - state enum typedef (IDLE, SEND, GAP).
  - IDLE_W1=1'b0 and IDLE_W2=1'b1 constants.
  - CNT_W helper function.
- One natural sub-module: wpair_run_stat, the equal-run counter and max tracker. It is instantiated only under WPAIR_MATCH_STAT_EN.

Test Plan (PAIRS=8, GAP=2 unless stated):
- Basic frame: after reset, load_w1=8'hA5, load_w2=8'h5A accepted at edge k.
  - Cycles k+1..k+8: (w1,w2) = (1,0),(0,1),(1,0),(0,1),(0,1),(1,0),(0,1),(1,0), w_valid=1.
  - done=1 only in cycle k+8.
  - Cycles k+9..k+10: (0,1) with w_valid=0.
  - load_ready=1 from cycle k+11.
- Statistics (WPAIR_MATCH_STAT_EN): load_w1=8'hFF, load_w2=8'h0F.
  - Pairs 0-3 equal, pairs 4-7 unequal, so match_max=4 from cycle k+9.
  - Next frame 8'h00/8'h00 gives match_max=8.
- Back-to-back: load_valid held high with 3 frames queued.
  - Exactly 3 idle (0,1) cycles between the last pair of one frame and the first pair of the next.
  - Exactly 3 done pulses.
- Load port ignored while busy: toggle load_w1/load_w2 and load_valid during SEND.
  - The serial stream is unchanged.
  - load_ready stays 0.
- Reset mid-frame: Resetn=0 asynchronously during pair 3.
  - Same-cycle outputs: w1=0, w2=1, w_valid=0, busy=0, match_max=0.
  - No done pulse.
  - After release, load_ready=1 and a fresh frame transmits correctly.
- GAP=0 build: two frames back-to-back.
  - Exactly 1 idle cycle between frames.
  - done is followed directly by IDLE.
